// File: rtl/fetch_sequencer.sv
// fetch_sequencer: two-phase (fetch/execute) instruction sequencer.
// Holds the program counter, the latched opcode/operand and the ALU flags,
// and forms the microcode address {instr, c_flag, z_flag, phase}.
// Control-word bits (inc_pc, load_pc, load_flags) act in either phase.
// enable is a plain advance strobe: when low every register holds.

module fetch_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  prog_byte,
    input  logic        inc_pc,
    input  logic        load_pc,
    input  logic        load_flags,
    input  logic        alu_carry,
    input  logic        alu_zero,
    output logic [11:0] pc,
    output logic [3:0]  instr,
    output logic [3:0]  oprnd,
    output logic        phase,
    output logic        c_flag,
    output logic        z_flag,
    output logic [6:0]  ucode_addr
);

    typedef enum logic {
        PH_FETCH = 1'b0,
        PH_EXEC  = 1'b1
    } phase_t;

    phase_t      r_phase;
    phase_t      w_phase_next;
    logic [11:0] r_pc;
    logic [11:0] w_pc_next;
    logic [3:0]  r_instr;
    logic [3:0]  r_oprnd;
    logic        r_c_flag;
    logic        r_z_flag;

    // Phase state register: reset wins over enable; holds while disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase <= PH_FETCH;
        end else if (enable) begin
            r_phase <= w_phase_next;
        end
    end

    // Next phase: strict fetch/execute alternation on every enabled clock.
    always_comb begin
        w_phase_next = PH_FETCH;
        case (r_phase)
            PH_FETCH: w_phase_next = PH_EXEC;
            PH_EXEC:  w_phase_next = PH_FETCH;
            default:  w_phase_next = PH_FETCH;
        endcase
    end

    // Next pc: jump target (old operand high, byte at pc low) beats increment.
    always_comb begin
        w_pc_next = r_pc;
        if (load_pc) begin
            w_pc_next = {r_oprnd, prog_byte};
        end else if (inc_pc) begin
            w_pc_next = r_pc + 12'd1;
        end
    end

    // Datapath registers: pc, fetched instruction and ALU flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= 12'h000;
            r_instr  <= 4'h0;
            r_oprnd  <= 4'h0;
            r_c_flag <= 1'b0;
            r_z_flag <= 1'b0;
        end else if (enable) begin
            r_pc <= w_pc_next;
            if (r_phase == PH_FETCH) begin
                r_instr <= prog_byte[7:4];
                r_oprnd <= prog_byte[3:0];
            end
            if (load_flags) begin
                r_c_flag <= alu_carry;
                r_z_flag <= alu_zero;
            end
        end
    end

    // Output drive and microcode address assembly.
    always_comb begin
        pc         = r_pc;
        instr      = r_instr;
        oprnd      = r_oprnd;
        phase      = (r_phase == PH_EXEC);
        c_flag     = r_c_flag;
        z_flag     = r_z_flag;
        ucode_addr = {r_instr, r_c_flag, r_z_flag, phase};
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios plus randomized traffic, checked
// against a behavioural model of the fetch/execute sequencer.

module tb_fetch_sequencer;

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        reset;
    logic        enable;
    logic [7:0]  prog_byte;
    logic        inc_pc;
    logic        load_pc;
    logic        load_flags;
    logic        alu_carry;
    logic        alu_zero;
    logic [11:0] pc;
    logic [3:0]  instr;
    logic [3:0]  oprnd;
    logic        phase;
    logic        c_flag;
    logic        z_flag;
    logic [6:0]  ucode_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .prog_byte  (prog_byte),
        .inc_pc     (inc_pc),
        .load_pc    (load_pc),
        .load_flags (load_flags),
        .alu_carry  (alu_carry),
        .alu_zero   (alu_zero),
        .pc         (pc),
        .instr      (instr),
        .oprnd      (oprnd),
        .phase      (phase),
        .c_flag     (c_flag),
        .z_flag     (z_flag),
        .ucode_addr (ucode_addr)
    );

    // ---------------- scoreboard counters ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int       m_pc;
    int       m_instr;
    int       m_oprnd;
    int       m_phase;
    int       m_c;
    int       m_z;

    task automatic model_step();
        int new_pc;
        if (reset) begin
            m_pc = 0; m_instr = 0; m_oprnd = 0; m_phase = 0; m_c = 0; m_z = 0;
        end else if (enable) begin
            if (load_pc)     new_pc = m_oprnd * 256 + int'(prog_byte);
            else if (inc_pc) new_pc = (m_pc + 1) % 4096;
            else             new_pc = m_pc;
            if (m_phase == 0) begin
                m_instr = int'(prog_byte) / 16;
                m_oprnd = int'(prog_byte) % 16;
            end
            if (load_flags) begin
                m_c = int'(alu_carry);
                m_z = int'(alu_zero);
            end
            m_pc    = new_pc;
            m_phase = 1 - m_phase;
        end
    endtask

    task automatic check_model(input string tag);
        int exp_ua;
        exp_ua = m_instr * 8 + m_c * 4 + m_z * 2 + m_phase;
        check_val({tag, ".pc"},    32'(pc),         32'(m_pc));
        check_val({tag, ".instr"}, 32'(instr),      32'(m_instr));
        check_val({tag, ".oprnd"}, 32'(oprnd),      32'(m_oprnd));
        check_val({tag, ".phase"}, 32'(phase),      32'(m_phase));
        check_val({tag, ".c"},     32'(c_flag),     32'(m_c));
        check_val({tag, ".z"},     32'(z_flag),     32'(m_z));
        check_val({tag, ".ua"},    32'(ucode_addr), 32'(exp_ua));
    endtask

    // ---------------- driver ----------------
    // Apply inputs away from the edge, clock once, then compare #1 later.
    task automatic drive(input string tag, input logic rst, input logic en,
                         input logic [7:0] pb, input logic inc, input logic ld,
                         input logic lf, input logic ac, input logic az);
        reset = rst; enable = en; prog_byte = pb;
        inc_pc = inc; load_pc = ld; load_flags = lf;
        alu_carry = ac; alu_zero = az;
        @(posedge clk);
        model_step();
        #1;
        check_model(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; enable = 1'b0; prog_byte = 8'h00;
        inc_pc = 1'b0; load_pc = 1'b0; load_flags = 1'b0;
        alu_carry = 1'b0; alu_zero = 1'b0;
        #2;

        // reset state
        drive("rst", 1, 1, 8'hFF, 1, 1, 1, 1, 1);
        check_val("rst.ua_const", 32'(ucode_addr), 32'h00);

        // first fetch after reset
        drive("fetch5A", 0, 1, 8'h5A, 1, 0, 0, 0, 0);
        check_val("fetch5A.pc",    32'(pc),         32'h001);
        check_val("fetch5A.instr", 32'(instr),      32'h5);
        check_val("fetch5A.oprnd", 32'(oprnd),      32'hA);
        check_val("fetch5A.ua",    32'(ucode_addr), 32'b0101_001);

        // execute phase holds instr/oprnd even with a new prog_byte
        drive("exec_hold", 0, 1, 8'h77, 0, 0, 0, 0, 0);
        check_val("exec_hold.instr", 32'(instr), 32'h5);

        // build pc=FFF: fetch operand F, then load with byte FF
        drive("fetchF", 0, 1, 8'h2F, 0, 0, 0, 0, 0);
        drive("loadFFF", 0, 1, 8'hFF, 0, 1, 0, 0, 0);
        check_val("loadFFF.pc", 32'(pc), 32'hFFF);
        drive("wrap", 0, 1, 8'h00, 1, 0, 0, 0, 0);
        check_val("wrap.pc", 32'(pc), 32'h000);

        // load beats inc: operand 3, byte C4
        drive("exec_pad", 0, 1, 8'h00, 0, 0, 0, 0, 0);
        drive("fetch3", 0, 1, 8'h13, 0, 0, 0, 0, 0);
        drive("ld_inc", 0, 1, 8'hC4, 1, 1, 0, 0, 0);
        check_val("ld_inc.pc", 32'(pc), 32'h3C4);

        // flag capture then hold with toggled ALU inputs
        drive("flags", 0, 1, 8'h00, 0, 0, 1, 1, 0);
        check_val("flags.c",  32'(c_flag),          32'h1);
        check_val("flags.z",  32'(z_flag),          32'h0);
        check_val("flags.ua", 32'(ucode_addr[2:1]), 32'b10);
        drive("flags_hold", 0, 1, 8'h00, 0, 0, 0, 0, 1);
        check_val("flags_hold.c", 32'(c_flag), 32'h1);
        check_val("flags_hold.z", 32'(z_flag), 32'h0);

        // enable low for 5 clocks with all controls asserted
        for (int i = 0; i < 5; i++)
            drive("disabled", 0, 0, 8'hE7, 1, 1, 1, 0, 1);
        check_val("disabled.c", 32'(c_flag), 32'h1);

        // reset without a clock edge must not change state
        reset = 1'b1;
        #2;
        check_val("async_rst.c",  32'(c_flag), 32'h1);
        check_val("async_rst.ph", 32'(phase),  32'(m_phase));
        reset = 1'b0;

        // get to phase=1 with pc=123, then reset mid-instruction
        if (m_phase == 1) drive("align", 0, 1, 8'h00, 0, 0, 0, 0, 0);
        drive("fetch1", 0, 1, 8'h11, 0, 0, 0, 0, 0);
        drive("load123", 0, 1, 8'h23, 0, 1, 0, 0, 0);
        drive("fetch_x", 0, 1, 8'h40, 0, 0, 1, 1, 1);
        check_val("pre_rst.pc", 32'(pc),    32'h123);
        check_val("pre_rst.ph", 32'(phase), 32'h1);
        drive("rst_mid", 1, 1, 8'hFF, 1, 1, 1, 1, 1);
        check_val("rst_mid.pc", 32'(pc),         32'h000);
        check_val("rst_mid.ua", 32'(ucode_addr), 32'h00);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive("rand",
                  logic'($urandom_range(0, 49) == 0),
                  logic'($urandom_range(0, 4) != 0),
                  8'($urandom_range(0, 255)),
                  logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 3) == 0),
                  logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 1)));
        end

        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: enable  input  1  when high, the sequencer advances one state per clock; when low, all state holds.
REQ-004 SHALL have port: prog_byte  input  8  program memory data at address pc; [7:4] opcode, [3:0] operand.
REQ-005 SHALL have port: inc_pc  input  1  control-word bit: increment pc.
REQ-006 SHALL have port: load_pc  input  1  control-word bit: load pc with the jump target.
REQ-007 SHALL have port: load_flags  input  1  control-word bit: capture ALU flags.
REQ-008 SHALL have port: alu_carry  input  1  ALU carry-out for the current cycle.
REQ-009 SHALL have port: alu_zero  input  1  ALU zero result for the current cycle.
REQ-010 SHALL have port: pc  output  12  program counter and program memory address.
REQ-011 SHALL have port: instr  output  4  latched opcode.
REQ-012 SHALL have port: oprnd  output  4  latched operand.
REQ-013 SHALL have port: phase  output  1  0 = fetch, 1 = execute.
REQ-014 SHALL have port: c_flag  output  1  registered carry flag.
REQ-015 SHALL have port: z_flag  output  1  registered zero flag.
REQ-016 SHALL have port: ucode_addr  output  7  microcode address {instr, c_flag, z_flag, phase}.

Function
REQ-017 SHALL drive ucode_addr combinationally as {instr[3:0], c_flag, z_flag, phase}, with instr at [6:3] and phase at [0].
REQ-018 SHALL invert phase on every enabled clock, giving a strict fetch/execute alternation.
REQ-019 SHALL, on an enabled clock with phase==0, latch instr<=prog_byte[7:4] and oprnd<=prog_byte[3:0].
REQ-020 SHALL hold instr and oprnd on enabled clocks with phase==1, so execute microcode sees the fetched instruction.
REQ-021 SHALL, on an enabled clock with load_pc==1, load pc<={oprnd, prog_byte}.
- Jump target = 4-bit operand of the current instruction (high) concatenated with the byte at pc (low).
REQ-022 SHALL, on an enabled clock with load_pc==0 and inc_pc==1, set pc<=pc+1 modulo 4096.
- Wrap-around: 12'hFFF -> 12'h000, no flag or other side effect.
REQ-023 SHALL give load_pc priority over inc_pc when both are asserted in the same cycle.
REQ-024 SHALL hold pc when neither load_pc nor inc_pc is asserted.
REQ-025 SHALL, on an enabled clock with load_flags==1, capture c_flag<=alu_carry and z_flag<=alu_zero; otherwise hold both flags.
REQ-026 SHALL apply inc_pc, load_pc and load_flags in either phase.
REQ-027 SHALL ignore inc_pc, load_pc, load_flags and prog_byte, and hold all state, while enable==0.
REQ-028 SHALL make every register update visible on the cycle after the enabled edge.
- Microcode latency: one clock from instruction fetch to execute-phase address.

Reset
REQ-029 SHALL, on a rising clk edge with reset==1, set pc=12'h000, phase=0, instr=4'h0, oprnd=4'h0, c_flag=0 and z_flag=0, giving ucode_addr=7'h00.
REQ-030 SHALL give reset priority over enable and all control inputs, including a reset asserted mid-instruction (phase==1); the first cycle after reset is a fetch from address 0.
REQ-031 SHALL have reset act only on a clock edge; asserting reset without a clock edge does not change state.

Verification
REQ-032 SHALL be verified with: reset, enable=1, prog_byte=8'h5A, inc_pc=1 for 1 clk -> instr=5, oprnd=A, phase=1, pc=001, ucode_addr=7'b0101_001.
REQ-033 SHALL be verified with: pc=12'hFFF, inc_pc=1, load_pc=0, enabled clk -> pc=12'h000.
REQ-034 SHALL be verified with: oprnd=4'h3, prog_byte=8'hC4, load_pc=1 and inc_pc=1 on the same clk -> pc=12'h3C4 (load wins).
REQ-035 SHALL be verified with: load_flags=1, alu_carry=1, alu_zero=0 -> c_flag=1, z_flag=0, ucode_addr[2:1]=2'b10; next clk with load_flags=0 and alu inputs toggled -> flags unchanged.
REQ-036 SHALL be verified with: enable=0 for 5 clks with inc_pc/load_pc/load_flags=1 -> pc, phase, instr, oprnd and flags all unchanged.
REQ-037 SHALL be verified with: reset=1 asserted during phase=1 with pc=12'h123 -> next cycle pc=000, phase=0, flags=0, ucode_addr=7'h00.
